// File: rtl/cpu_pkg.sv
// Shared types and constants for the 4-bit accumulator CPU sequencing controller.
package cpu_pkg;

  localparam int OPCODE_W = 4;
  localparam int IMM_W    = 4;

  typedef enum logic [OPCODE_W-1:0] {
    OP_ADD_A    = 4'b0000,
    OP_MOV_A_B  = 4'b0001,
    OP_IN_A     = 4'b0010,
    OP_MOV_A_IM = 4'b0011,
    OP_MOV_B_A  = 4'b0100,
    OP_ADD_B    = 4'b0101,
    OP_IN_B     = 4'b0110,
    OP_MOV_B_IM = 4'b0111,
    OP_OUT_B    = 4'b1001,
    OP_OUT_IM   = 4'b1011,
    OP_JNC      = 4'b1110,
    OP_JMP      = 4'b1111
  } opcode_t;

  typedef enum logic [1:0] {
    SEL_A    = 2'd0,
    SEL_B    = 2'd1,
    SEL_IN   = 2'd2,
    SEL_ZERO = 2'd3
  } sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    HALT  = 2'd3
  } state_t;

endpackage

// File: rtl/cpu_ctrl_if.sv
// ROM and datapath-control bundle between the controller and the rest of the CPU.
interface cpu_ctrl_if #(parameter int PC_W = 4);
  import cpu_pkg::*;

  logic [PC_W-1:0]  addr;
  logic [7:0]       data;
  logic             carry;
  logic [IMM_W-1:0] imm;
  sel_t             sel;
  logic             ld_a;
  logic             ld_b;
  logic             ld_out;
  logic             ld_flag;

  modport master (
    output addr, imm, sel, ld_a, ld_b, ld_out, ld_flag,
    input  data, carry
  );

  modport slave (
    input  addr, imm, sel, ld_a, ld_b, ld_out, ld_flag,
    output data, carry
  );

endinterface

// File: rtl/cpu_decode.sv
// Combinational instruction decoder: opcode and carry to ALU source, load enables and jump.
module cpu_decode
  import cpu_pkg::*;
(
  input  logic [OPCODE_W-1:0] op,
  input  logic                carry,
  output sel_t                sel,
  output logic                ld_a,
  output logic                ld_b,
  output logic                ld_out,
  output logic                jump
);

  // Opcode table; unlisted opcodes fall through as NOP
  always_comb begin
    sel    = SEL_A;
    ld_a   = 1'b0;
    ld_b   = 1'b0;
    ld_out = 1'b0;
    jump   = 1'b0;
    case (op)
      OP_ADD_A:    begin sel = SEL_A;    ld_a   = 1'b1; end
      OP_ADD_B:    begin sel = SEL_B;    ld_b   = 1'b1; end
      OP_MOV_A_IM: begin sel = SEL_ZERO; ld_a   = 1'b1; end
      OP_MOV_B_IM: begin sel = SEL_ZERO; ld_b   = 1'b1; end
      OP_MOV_A_B:  begin sel = SEL_B;    ld_a   = 1'b1; end
      OP_MOV_B_A:  begin sel = SEL_A;    ld_b   = 1'b1; end
      OP_IN_A:     begin sel = SEL_IN;   ld_a   = 1'b1; end
      OP_IN_B:     begin sel = SEL_IN;   ld_b   = 1'b1; end
      OP_OUT_B:    begin sel = SEL_B;    ld_out = 1'b1; end
      OP_OUT_IM:   begin sel = SEL_ZERO; ld_out = 1'b1; end
      OP_JMP:      begin jump = 1'b1; end
      OP_JNC:      begin jump = ~carry; end
      default:     begin jump = 1'b0; end
    endcase
  end

endmodule

// File: rtl/cpu_ctrl.sv
// Sequencing controller: PC, instruction register, run/step/halt FSM and load-enable gating.
module cpu_ctrl
  import cpu_pkg::*;
#(
  parameter int PC_W             = 4,
  parameter bit HALT_ON_SELF_JMP = 1'b1
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       tick,
  input  logic       run,
  input  logic       step,
  output logic       halted,
  cpu_ctrl_if.master bus
);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            step_prev_q, step_prev_d;
  logic            pending_q, pending_d;

  sel_t            dec_sel_s;
  logic            dec_ld_a_s, dec_ld_b_s, dec_ld_out_s, dec_jump_s;
  logic            step_edge_s;
  logic            self_jmp_s;
  logic [PC_W-1:0] jump_tgt_s;

  cpu_decode u_decode (
    .op     (ir_q[7:4]),
    .carry  (bus.carry),
    .sel    (dec_sel_s),
    .ld_a   (dec_ld_a_s),
    .ld_b   (dec_ld_b_s),
    .ld_out (dec_ld_out_s),
    .jump   (dec_jump_s)
  );

  assign step_edge_s = step & ~step_prev_q;
  assign jump_tgt_s  = PC_W'(ir_q[IMM_W-1:0]);
  // Only an unconditional JMP onto itself halts; a JNC self-loop can still exit on carry
  assign self_jmp_s  = HALT_ON_SELF_JMP && (ir_q[7:4] == OP_JMP) && (jump_tgt_s == pc_q);

  assign bus.addr = pc_q;
  assign bus.imm  = ir_q[IMM_W-1:0];
  assign bus.sel  = dec_sel_s;
  assign halted   = (state_q == HALT);

  // Next-state, PC/IR update, step-pending bookkeeping and tick-gated load enables
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    step_prev_d = step;
    pending_d   = 1'b0;
    bus.ld_a    = 1'b0;
    bus.ld_b    = 1'b0;
    bus.ld_out  = 1'b0;
    bus.ld_flag = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick && (run || pending_q || step_edge_s)) begin
          state_d   = FETCH;
          pending_d = 1'b0;
        end else begin
          pending_d = pending_q | step_edge_s;
        end
      end
      FETCH: begin
        if (tick) begin
          ir_d    = bus.data;
          state_d = EXEC;
        end else begin
          ir_d    = ir_q;
        end
      end
      EXEC: begin
        if (tick) begin
          bus.ld_a    = dec_ld_a_s;
          bus.ld_b    = dec_ld_b_s;
          bus.ld_out  = dec_ld_out_s;
          bus.ld_flag = 1'b1;
          pc_d        = dec_jump_s ? jump_tgt_s : pc_q + PC_W'(1'b1);
          if (self_jmp_s) begin
            state_d = HALT;
          end else if (run) begin
            state_d = FETCH;
          end else begin
            state_d = IDLE;
          end
        end else begin
          state_d = EXEC;
        end
      end
      HALT: begin
        state_d = HALT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, PC, IR and step edge-detector registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      pc_q        <= '0;
      ir_q        <= 8'h00;
      step_prev_q <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      step_prev_q <= step_prev_d;
      pending_q   <= pending_d;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Directed self-checking bench for cpu_ctrl driving a small ROM model.
module tb_cpu_ctrl;
  import cpu_pkg::*;

  logic clk;
  logic n_rst;
  logic tick;
  logic run;
  logic step;
  logic halted;
  logic carry;
  logic [7:0] rom [16];

  int total = 0;
  int bad   = 0;
  int a_cnt, b_cnt, out_cnt, flag_cnt;
  int viol;

  cpu_ctrl_if #(.PC_W(4)) bus ();

  assign bus.data  = rom[bus.addr];
  assign bus.carry = carry;

  cpu_ctrl #(.PC_W(4), .HALT_ON_SELF_JMP(1'b1)) dut (
    .clk    (clk),
    .n_rst  (n_rst),
    .tick   (tick),
    .run    (run),
    .step   (step),
    .halted (halted),
    .bus    (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    a_cnt = 0; b_cnt = 0; out_cnt = 0; flag_cnt = 0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (bus.ld_a)    a_cnt++;
      if (bus.ld_b)    b_cnt++;
      if (bus.ld_out)  out_cnt++;
      if (bus.ld_flag) flag_cnt++;
    end
  endtask

  task automatic do_step();
    step = 1'b1;
    cycles(4);
    step = 1'b0;
    cycles(2);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) rom[i] = 8'h80;
    rom[0]  = 8'h35;   // MOV A,5
    rom[1]  = 8'h73;   // MOV B,3
    rom[2]  = 8'h17;   // MOV A,B
    rom[3]  = 8'hE9;   // JNC 9
    rom[4]  = 8'hFF;   // JMP 15
    rom[9]  = 8'hF3;   // JMP 3
    rom[15] = 8'h00;   // ADD A,0
    n_rst = 1'b0; tick = 1'b0; run = 1'b0; step = 1'b0; carry = 1'b0;
    clr();

    #12;
    chk("rst_addr", 8'(bus.addr), 8'h0);
    chk("rst_halted", 8'(halted), 8'h0);
    chk("rst_ld", {4'h0, bus.ld_a, bus.ld_b, bus.ld_out, bus.ld_flag}, 8'h0);
    chk("rst_sel", 8'(bus.sel), 8'h0);
    chk("rst_imm", 8'(bus.imm), 8'h0);
    @(posedge clk); #1;
    n_rst = 1'b1;

    // free-run first instruction
    run = 1'b1; tick = 1'b1;
    cycles(1);
    chk("fetch_addr", 8'(bus.addr), 8'h0);
    chk("fetch_ld_a", 8'(bus.ld_a), 8'h0);
    cycles(1);
    chk("exec_ld_a", 8'(bus.ld_a), 8'h1);
    chk("exec_ld_b", 8'(bus.ld_b), 8'h0);
    chk("exec_ld_flag", 8'(bus.ld_flag), 8'h1);
    chk("exec_sel", 8'(bus.sel), 8'h3);
    chk("exec_imm", 8'(bus.imm), 8'h5);
    chk("exec_addr", 8'(bus.addr), 8'h0);
    run = 1'b0;
    cycles(1);
    chk("after_addr", 8'(bus.addr), 8'h1);
    chk("after_ld_a", 8'(bus.ld_a), 8'h0);

    // two step edges ten cycles apart
    clr();
    cycles(3);
    chk("idle_hold_addr", 8'(bus.addr), 8'h1);
    step = 1'b1; cycles(5);
    step = 1'b0; cycles(5);
    step = 1'b1; cycles(5);
    step = 1'b0; cycles(5);
    chk("step_ld_a_cnt", 8'(a_cnt), 8'd1);
    chk("step_ld_b_cnt", 8'(b_cnt), 8'd1);
    chk("step_ld_out_cnt", 8'(out_cnt), 8'd0);
    chk("step_flag_cnt", 8'(flag_cnt), 8'd2);
    chk("step_addr", 8'(bus.addr), 8'h3);

    // JNC taken, loop back, JNC not taken
    clr();
    carry = 1'b0;
    do_step();
    chk("jnc_taken_addr", 8'(bus.addr), 8'h9);
    do_step();
    chk("jmp_back_addr", 8'(bus.addr), 8'h3);
    carry = 1'b1;
    do_step();
    chk("jnc_not_taken_addr", 8'(bus.addr), 8'h4);
    chk("jmp_flag_cnt", 8'(flag_cnt), 8'd3);
    chk("jmp_ld_cnt", 8'(a_cnt + b_cnt + out_cnt), 8'd0);

    // PC wrap from 15 to 0
    clr();
    carry = 1'b0;
    do_step();
    chk("jmp15_addr", 8'(bus.addr), 8'hF);
    do_step();
    chk("wrap_addr", 8'(bus.addr), 8'h0);
    chk("wrap_ld_a_cnt", 8'(a_cnt), 8'd1);

    // sparse tick, run dropped mid-FETCH
    clr();
    run = 1'b1; tick = 1'b0;
    cycles(3);
    chk("notick_addr", 8'(bus.addr), 8'h0);
    tick = 1'b1;
    cycles(1);
    run = 1'b0; tick = 1'b0;
    cycles(3);
    chk("notick_ld_cnt", 8'(a_cnt + b_cnt + out_cnt + flag_cnt), 8'd0);
    tick = 1'b1;
    cycles(1);
    chk("tick_exec_ld_a", 8'(bus.ld_a), 8'h1);
    chk("tick_exec_sel", 8'(bus.sel), 8'h3);
    tick = 1'b0;
    #1;
    chk("notick_exec_ld_a", 8'(bus.ld_a), 8'h0);
    cycles(3);
    chk("exec_hold_addr", 8'(bus.addr), 8'h0);
    tick = 1'b1;
    cycles(1);
    chk("tick_done_addr", 8'(bus.addr), 8'h1);
    tick = 1'b0; cycles(2);
    tick = 1'b1; cycles(2);
    chk("tick_ld_a_cnt", 8'(a_cnt), 8'd1);
    chk("tick_idle_addr", 8'(bus.addr), 8'h1);

    // self-jump halts; only reset leaves HALT
    rom[2] = 8'hF2;
    clr();
    run = 1'b1; tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step = ~step;
      cycles(1);
    end
    chk("halt_flag", 8'(halted), 8'h1);
    chk("halt_addr", 8'(bus.addr), 8'h2);
    chk("halt_ld_b_cnt", 8'(b_cnt), 8'd1);
    clr();
    viol = 0;
    for (int i = 0; i < 20; i++) begin
      step = ~step;
      cycles(1);
      if (bus.addr !== 4'h2 || halted !== 1'b1) viol++;
    end
    chk("halt_hold_viol", 8'(viol), 8'd0);
    chk("halt_ld_cnt", 8'(a_cnt + b_cnt + out_cnt + flag_cnt), 8'd0);
    run = 1'b0; step = 1'b0;
    n_rst = 1'b0;
    #2;
    chk("rst2_addr", 8'(bus.addr), 8'h0);
    chk("rst2_halted", 8'(halted), 8'h0);
    chk("rst2_imm", 8'(bus.imm), 8'h0);
    @(posedge clk); #1;
    n_rst = 1'b1;
    cycles(3);
    chk("post_rst_addr", 8'(bus.addr), 8'h0);
    chk("post_rst_halted", 8'(halted), 8'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cpu_ctrl.md
Name: cpu_ctrl

Overview:
Sequencing controller for the 4-bit accumulator CPU datapath. Owns the program counter and the instruction register, and decodes each instruction into register load enables and an ALU source select. Provides run, single-step and halt modes so the board can be stepped from a button. Sits between program ROM (addr/data) and the A/B/OUT/carry registers.

Parameters:
PC_W, 4, program counter width; ROM depth is 2**PC_W.
HALT_ON_SELF_JMP, 1, when 1, JMP to the instruction's own address enters HALT.

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
tick  input  1  advance enable from prescaler; FSM and loads move only when tick=1
run  input  1  level; 1 = free-running execution
step  input  1  level from debounced button; each rising edge executes one instruction when run=0
data  input  8  ROM word at addr: [7:4] opcode, [3:0] immediate
carry  input  1  carry flag from datapath
addr  output  PC_W  program counter, drives ROM address
imm  output  4  immediate from instruction register
sel  output  2  ALU source: 0=A, 1=B, 2=IN(switch), 3=ZERO; ALU result = src + imm
ld_a  output  1  load A with ALU result
ld_b  output  1  load B with ALU result
ld_out  output  1  load OUT (LED) with ALU result
ld_flag  output  1  load carry flag from ALU carry-out
halted  output  1  1 while in HALT

Behaviour:
- Reset (async, n_rst=0): state=IDLE, addr=0, ir=0, all ld_* = 0, sel=0, imm=0, halted=0, step edge detector cleared (previous step sampled = 0).
- States: IDLE, FETCH, EXEC, HALT. All transitions are qualified by tick=1; with tick=0 the state and all registers hold and ld_* = 0.
- IDLE -> FETCH when run=1, or when a step rising edge is pending; otherwise IDLE holds.
- FETCH: ir <= data. Next state EXEC.
- EXEC: ld_* asserted for exactly this one cycle (tick=1); pc updated at the end of the cycle. Next state FETCH if run=1, else IDLE. Enters HALT instead on self-jump when HALT_ON_SELF_JMP=1.
- Latency: 2 ticked cycles per instruction.
- Step edge: detected on every clk (not tick-gated) and latched as pending. Cleared on leaving IDLE. An edge arriving outside IDLE is discarded; steps are not queued.
- run and a pending step together: run dominates; pending step cleared.
- run deasserted during FETCH/EXEC: the current instruction completes, then IDLE.
- Decode (op -> sel, loads, pc):
  0000 ADD A,Im: sel=A, ld_a.
  0101 ADD B,Im: sel=B, ld_b.
  0011 MOV A,Im: sel=ZERO, ld_a.
  0111 MOV B,Im: sel=ZERO, ld_b.
  0001 MOV A,B: sel=B, ld_a.
  0100 MOV B,A: sel=A, ld_b.
  0010 IN A: sel=IN, ld_a.
  0110 IN B: sel=IN, ld_b.
  1001 OUT B: sel=B, ld_out.
  1011 OUT Im: sel=ZERO, ld_out.
  1111 JMP Im: pc <= imm.
  1110 JNC Im: pc <= imm if carry=0, else pc+1.
  All other opcodes: NOP, pc+1.
- ld_flag is asserted in every EXEC cycle, including jumps and NOPs. JNC samples carry during EXEC, before that cycle's flag update.
- pc+1 wraps from 2**PC_W-1 to 0. Immediates are zero-extended to PC_W.
- HALT: holds addr and asserts halted=1. Only n_rst exits HALT; run and step are ignored.
- Outside EXEC: ld_* = 0. sel and imm reflect ir continuously.

Decomposition:
- Package cpu_pkg holds:
  - opcode_t enum (the 12 opcodes above);
  - sel_t enum (SEL_A, SEL_B, SEL_IN, SEL_ZERO);
  - state_t enum (IDLE, FETCH, EXEC, HALT);
  - OPCODE_W=4, IMM_W=4.
- Sub-module cpu_decode: purely combinational, opcode + carry -> sel, ld_a, ld_b, ld_out, jump. cpu_ctrl holds the FSM, pc, ir and step edge detection.

Test Plan:
- Reset then run=1, tick=1, ROM[0]=0x35 (MOV A,5) -> cycle 2 ld_a=1, sel=3, imm=5; addr=1 after that cycle.
- run=0, two step rising edges 10 cycles apart -> exactly two instructions executed; addr 0->1->2; ld_* pulses exactly twice.
- ROM[3]=0xE9 (JNC 9): carry=0 -> addr=9; rerun with carry=1 -> addr=4.
- PC_W=4, ROM[15]=0x00 (ADD A,0) -> next addr=0 (wrap).
- ROM[2]=0xF2 (JMP 2) -> halted=1, addr stays 2 for 20 cycles with run=1 and step toggling; n_rst pulse -> addr=0, halted=0.
- tick toggling 1-of-4, run deasserted mid-FETCH -> instruction still completes (ld_a pulse on a tick cycle), then IDLE; no ld_* while tick=0.
